// File: rtl/vertex_pkg.sv
// Shared types for the vertex transform path: fp16 lanes,
// 4-vectors, 4x4 matrices and the matmul scheduler states.
package vertex_pkg;

    typedef logic [15:0] fp16_t;
    typedef fp16_t [3:0] vec4_t;
    typedef fp16_t [15:0] mat4_t;

    typedef enum logic [1:0] {
        EMPTY,
        LOAD,
        RUN,
        DRAIN
    } sched_state_e;

    localparam fp16_t FP16_ONE  = 16'h3C00;
    localparam fp16_t FP16_ZERO = 16'h0000;

endpackage

// File: rtl/matmul_sched_if.sv
// Bundle of the matrix, vertex-in, vertex-out and matmul-side
// signals around the scheduler.
interface matmul_sched_if;
    import vertex_pkg::*;

    logic  mat_valid;
    logic  mat_ready;
    fp16_t mat_data;
    logic  vin_valid;
    logic  vin_ready;
    vec4_t vin_data;
    logic  vout_valid;
    logic  vout_ready;
    vec4_t vout_data;
    mat4_t mm_a;
    vec4_t mm_b;
    vec4_t mm_x;
    logic  busy;
    logic  mat_loaded;

    modport slave (
        input  mat_valid, mat_data,
        input  vin_valid, vin_data,
        input  vout_ready, mm_x,
        output mat_ready, vin_ready,
        output vout_valid, vout_data,
        output mm_a, mm_b,
        output busy, mat_loaded
    );

    modport master (
        output mat_valid, mat_data,
        output vin_valid, vin_data,
        output vout_ready, mm_x,
        input  mat_ready, vin_ready,
        input  vout_valid, vout_data,
        input  mm_a, mm_b,
        input  busy, mat_loaded
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; read data is the head
// entry and holds until popped.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && (cnt_q != CW'(DEPTH));
    assign do_pop  = pop_i && (cnt_q != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/matmul_sched.sv
// Sequencer for the 4x4 fp16 matmul: matrix load, credit-based
// vertex admission, in-flight tracking and result buffering.
module matmul_sched
    import vertex_pkg::*;
#(
    parameter int MM_LATENCY = 6,
    parameter int FIFO_DEPTH = 8
) (
    input logic           clk,
    input logic           rst,
    matmul_sched_if.slave bus
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    sched_state_e          state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    mat4_t                 mm_a_q;
    vec4_t                 mm_b_q;
    logic [MM_LATENCY-1:0] vld_sr_q;
    logic [CW-1:0]         infl_q, infl_d;
    logic [CW-1:0]         occ_q, occ_d;
    logic                  mat_ready_q, mat_ready_d;
    logic                  vin_ready_q, vin_ready_d;
    logic                  loaded_q, loaded_d;
    logic                  busy_q, busy_d;

    logic          beat;
    logic          acc;
    logic          push;
    logic          pop;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_vld;

    assign beat     = bus.mat_valid && mat_ready_q;
    assign acc      = bus.vin_valid && vin_ready_q;
    assign push     = vld_sr_q[MM_LATENCY-1];
    assign fifo_vld = (fifo_cnt != '0);
    assign pop      = fifo_vld && bus.vout_ready;

    // occ counts every credit in use: in the pipe or in the FIFO
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            EMPTY, LOAD: begin
                if (beat) begin
                    cnt_d   = cnt_q + 4'd1;
                    state_d = (cnt_q == 4'd15) ? RUN : LOAD;
                end
            end
            RUN:   if (bus.mat_valid) state_d = DRAIN;
            DRAIN: if (infl_q == '0) state_d = LOAD;
        endcase
        infl_d      = infl_q + CW'(acc) - CW'(push);
        occ_d       = occ_q + CW'(acc) - CW'(pop);
        mat_ready_d = (state_d == EMPTY) || (state_d == LOAD);
        vin_ready_d = (state_d == RUN) &&
                      (occ_d < CW'(FIFO_DEPTH));
        loaded_d    = (state_d == RUN) || (state_d == DRAIN);
        busy_d      = (occ_d != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= EMPTY;
            cnt_q       <= '0;
            mm_a_q      <= '0;
            mm_b_q      <= '0;
            vld_sr_q    <= '0;
            infl_q      <= '0;
            occ_q       <= '0;
            mat_ready_q <= 1'b0;
            vin_ready_q <= 1'b0;
            loaded_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            if (beat) mm_a_q[cnt_q] <= bus.mat_data;
            if (acc)  mm_b_q <= bus.vin_data;
            vld_sr_q    <= {vld_sr_q[MM_LATENCY-2:0], acc};
            infl_q      <= infl_d;
            occ_q       <= occ_d;
            mat_ready_q <= mat_ready_d;
            vin_ready_q <= vin_ready_d;
            loaded_q    <= loaded_d;
            busy_q      <= busy_d;
        end
    end

    sync_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (bus.mm_x),
        .pop_i   (bus.vout_ready),
        .dout_o  (bus.vout_data),
        .count_o (fifo_cnt)
    );

    assign bus.mat_ready  = mat_ready_q;
    assign bus.vin_ready  = vin_ready_q;
    assign bus.vout_valid = fifo_vld;
    assign bus.mm_a       = mm_a_q;
    assign bus.mm_b       = mm_b_q;
    assign bus.busy       = busy_q;
    assign bus.mat_loaded = loaded_q;

endmodule

// File: tb/tb_matmul_sched.sv
// Directed bench for matmul_sched with a fixed-latency matmul
// stand-in and a result scoreboard.
module tb_matmul_sched;
    import vertex_pkg::*;

    localparam int L = 6;
    localparam int D = 8;

    logic clk;
    logic rst;

    matmul_sched_if bus ();

    matmul_sched #(
        .MM_LATENCY (L),
        .FIFO_DEPTH (D)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in matmul: rows hold one nonzero of 1.0 or 2.0
    function automatic vec4_t mm_fn(mat4_t a, vec4_t b);
        vec4_t x;
        x = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                if (a[4*r+c] == FP16_ONE)
                    x[r] = b[c];
                else if (a[4*r+c] == 16'h4000)
                    x[r] = b[c] + 16'h0400;
            end
        return x;
    endfunction

    vec4_t pipe [L-1];
    always_ff @(posedge clk) begin
        pipe[0] <= mm_fn(bus.mm_a, bus.mm_b);
        for (int i = 1; i < L - 1; i++)
            pipe[i] <= pipe[i-1];
    end
    assign bus.mm_x = pipe[L-2];

    int    n_chk;
    int    n_err;
    int    acc_cnt;
    int    occ;
    bit    rand_rdy;
    bit    hold_v;
    vec4_t held;
    vec4_t cur_exp;
    vec4_t expq [$];

    task automatic chk(string tag, logic [255:0] got,
                       logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        bit a;
        bit p;
        if (rand_rdy) bus.vout_ready = 1'($urandom_range(0, 1));
        if (hold_v && rst)
            chk("vout_stable", bus.vout_data, held);
        a = rst && bus.vin_valid && bus.vin_ready;
        p = rst && bus.vout_valid && bus.vout_ready;
        if (p) begin
            if (expq.size() == 0) chk("spurious", 1, 0);
            else chk("vout", bus.vout_data, expq.pop_front());
            occ--;
        end
        if (a) begin
            expq.push_back(cur_exp);
            acc_cnt++;
            occ++;
        end
        if (!rst) occ = 0;
        chk("credit", occ <= D, 1);
        hold_v = rst && bus.vout_valid && !bus.vout_ready;
        held   = bus.vout_data;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_mat(mat4_t m, int n);
        int idx;
        int g;
        bit b;
        idx = 0;
        g   = 0;
        bus.mat_valid = 1'b1;
        while (idx < n && g < 200) begin
            bus.mat_data = m[idx];
            b = bus.mat_ready;
            tick();
            if (b) idx++;
            g++;
        end
        bus.mat_valid = 1'b0;
        chk("mat_beats", idx, n);
        if (n == 16) begin
            chk("mm_a", bus.mm_a, m);
            chk("mat_loaded", bus.mat_loaded, 1);
        end
    endtask

    task automatic send(int n, vec4_t v, vec4_t e,
                        output int drops);
        int tgt;
        int g;
        cur_exp = e;
        bus.vin_data  = v;
        bus.vin_valid = 1'b1;
        tgt   = acc_cnt + n;
        g     = 0;
        drops = 0;
        while (acc_cnt < tgt && g < 200) begin
            if (!bus.vin_ready) drops++;
            tick();
            g++;
        end
        bus.vin_valid = 1'b0;
        chk("send_cnt", acc_cnt, tgt);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((expq.size() != 0 || bus.vout_valid) && g < 300) begin
            tick();
            g++;
        end
        chk("drain_q", expq.size(), 0);
        chk("drain_vout", bus.vout_valid, 0);
    endtask

    task automatic do_reset();
        bus.vin_valid = 1'b0;
        bus.mat_valid = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        expq.delete();
        hold_v = 1'b0;
        chk("rst_vout", bus.vout_valid, 0);
        chk("rst_vin_rdy", bus.vin_ready, 0);
        chk("rst_mat_rdy", bus.mat_ready, 0);
        chk("rst_loaded", bus.mat_loaded, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_mm_a", bus.mm_a, 0);
        chk("rst_mm_b", bus.mm_b, 0);
    endtask

    mat4_t ident;
    mat4_t diag2;
    mat4_t rev;
    vec4_t v1;
    vec4_t e2;
    vec4_t er;

    initial begin
        int d;
        int w;
        int lat;
        int base;
        int stale;
        n_chk = 0;
        n_err = 0;
        acc_cnt = 0;
        occ = 0;
        rand_rdy = 1'b0;
        hold_v = 1'b0;
        held = '0;
        cur_exp = '0;
        for (int i = 0; i < 16; i++) begin
            ident[i] = (i % 5 == 0) ? FP16_ONE : FP16_ZERO;
            diag2[i] = (i % 5 == 0) ? 16'h4000 : FP16_ZERO;
            rev[i]   = (i / 4 + i % 4 == 3) ? FP16_ONE : FP16_ZERO;
        end
        v1 = {16'h4400, 16'h4200, 16'h4000, 16'h3C00};
        e2 = {16'h4800, 16'h4600, 16'h4400, 16'h4000};
        er = {16'h3C00, 16'h4000, 16'h4200, 16'h4400};
        bus.mat_valid  = 1'b0;
        bus.mat_data   = '0;
        bus.vin_valid  = 1'b0;
        bus.vin_data   = '0;
        bus.vout_ready = 1'b1;
        rst = 1'b0;
        tick();
        do_reset();

        // identity and accept-to-valid latency
        load_mat(ident, 16);
        send(1, v1, v1, d);
        lat = 0;
        while (!bus.vout_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("latency", lat, L);
        drain();

        // back-to-back stream with diag(2.0)
        load_mat(diag2, 16);
        send(20, v1, e2, d);
        chk("stream_drops", d, 0);
        drain();

        // backpressure fills exactly the credit pool
        bus.vout_ready = 1'b0;
        bus.vin_valid  = 1'b1;
        base = acc_cnt;
        repeat (20) tick();
        bus.vin_valid = 1'b0;
        chk("fill_cnt", acc_cnt - base, D);
        chk("fill_vin_rdy", bus.vin_ready, 0);
        chk("fill_busy", bus.busy, 1);
        bus.vout_ready = 1'b1;
        drain();

        // new matrix with 3 in flight
        send(3, v1, e2, d);
        bus.mat_valid = 1'b1;
        bus.mat_data  = rev[0];
        w = 0;
        while (!bus.mat_ready && w < 30) begin
            tick();
            w++;
            if (w == 3) chk("drain_loaded", bus.mat_loaded, 1);
        end
        chk("drain_wait", w, 7);
        chk("drain_empty", expq.size(), 0);
        load_mat(rev, 16);
        send(1, v1, er, d);
        drain();

        // vertex and matrix together, random backpressure
        rand_rdy = 1'b1;
        send(2, v1, er, d);
        base = acc_cnt;
        bus.vin_valid = 1'b1;
        bus.mat_valid = 1'b1;
        bus.mat_data  = ident[0];
        tick();
        bus.vin_valid = 1'b0;
        chk("both_acc", acc_cnt - base, 1);
        chk("both_mat_rdy", bus.mat_ready, 0);
        chk("both_vin_rdy", bus.vin_ready, 0);
        chk("both_loaded", bus.mat_loaded, 1);
        load_mat(ident, 16);
        send(5, v1, v1, d);
        drain();
        rand_rdy = 1'b0;
        bus.vout_ready = 1'b1;

        // reset during load beat 7
        load_mat(diag2, 7);
        do_reset();
        tick();
        chk("rst_mat_rdy1", bus.mat_ready, 1);
        load_mat(diag2, 16);

        // reset with 4 in flight
        send(4, v1, e2, d);
        do_reset();
        stale = 0;
        repeat (10) begin
            if (bus.vout_valid) stale++;
            tick();
        end
        chk("no_stale", stale, 0);
        load_mat(ident, 16);
        send(1, v1, v1, d);
        drain();
        chk("idle_busy", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/matmul_sched.md
Name: matmul_sched

Overview:
- Sequencing controller for the 4x4 fp16 matrix-vector unit (`matmul`: a[15:0][15:0] × b[3:0][15:0] → x[3:0][15:0]).
- Loads the transform matrix as a 16-beat stream and admits vertices through a valid/ready handshake.
- Tracks in-flight vertices across the fixed-latency, non-stallable `matmul` pipeline and buffers results in an output FIFO.
- Credit-based admission guarantees no result is ever dropped. The block sits between the vertex fetch stage and the downstream vertex consumer.

Parameters:
- MM_LATENCY, 6, cycles from an mm_b update edge to the edge at which the matching mm_x is sampled.
- FIFO_DEPTH, 8, output result FIFO entries (power of two, ≥ 2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-low; one clock, no other reset.
- mat_valid  in  1  matrix beat valid.
- mat_ready  out  1  matrix beat accepted when mat_valid&&mat_ready.
- mat_data  in  16  fp16 matrix element; beat i writes a[i] (row-major, a[4r+c]).
- vin_valid  in  1  vertex valid.
- vin_ready  out  1  vertex accept.
- vin_data  in  [3:0][15:0]  vertex; lane j → b[j].
- vout_valid  out  1  result valid.
- vout_ready  in  1  downstream accept.
- vout_data  out  [3:0][15:0]  result; lane r = x[r].
- mm_a  out  [15:0][15:0]  matrix register to `matmul` a.
- mm_b  out  [3:0][15:0]  vertex register to `matmul` b.
- mm_x  in  [3:0][15:0]  `matmul` result.
- busy  out  1  in-flight ≠ 0 or FIFO non-empty.
- mat_loaded  out  1  a complete matrix is resident.

Behaviour:
- Reset (rst=0 at an edge), all outputs registered to these values:
  - state=EMPTY, mm_a=0, mm_b=0, valid pipeline cleared, FIFO emptied.
  - vout_valid=0, vin_ready=0, mat_ready=0, mat_loaded=0, busy=0, beat counter=0.
  - Reset mid-operation discards all in-flight results and the partially loaded matrix.
- States:
  - EMPTY: mat_ready=1; first accepted beat → LOAD.
  - LOAD: mat_ready=1. Each accepted beat writes mm_a[cnt] and increments cnt. Beat 15 accepted → cnt=0, mat_loaded=1, → RUN.
  - RUN: vin_ready = (inflight + fifo_count < FIFO_DEPTH); mat_ready=0. mat_valid seen → DRAIN.
  - DRAIN: vin_ready=0, mat_ready=0, mat_loaded stays 1. When inflight==0 (FIFO may still hold data) → LOAD with mat_loaded=0. The pending beat is accepted only in LOAD, never in DRAIN.
- Vertex issue:
  - On vin accept at edge k: mm_b<=vin_data and vld_sr[0]<=1; otherwise vld_sr[0]<=0. mm_b holds its last value when idle.
  - vld_sr is MM_LATENCY bits, shifting each cycle.
  - At edge k+MM_LATENCY, mm_x is written to the FIFO; vout_valid rises after that edge. Accept→vout_valid = MM_LATENCY cycles.
  - inflight = popcount(vld_sr), or an equivalent up/down counter of width clog2(FIFO_DEPTH+1).
- Credits:
  - inflight + fifo_count ≤ FIFO_DEPTH always, so a FIFO write never finds the FIFO full. The bench asserts this.
  - Admission uses registered counts. A same-cycle FIFO pop does not grant credit until the next cycle.
- FIFO:
  - Simultaneous push and pop when full: not reachable.
  - Simultaneous push and pop when empty: push occurs, pop is not (vout_valid was 0). No bypass.
  - Pointers wrap modulo FIFO_DEPTH.
  - vout_data is stable while vout_valid && !vout_ready.
- mat_valid arriving during LOAD is ordinary data. mat_valid with vin_valid in the same RUN cycle: the vertex is accepted if credit allows, then DRAIN.
- Results already in the FIFO stay drainable in every state except reset.

Decomposition:
- Shared package `vertex_pkg` holds:
  - typedef fp16_t (logic[15:0]), vec4_t ([3:0] fp16_t), mat4_t ([15:0] fp16_t).
  - state enum sched_state_e {EMPTY, LOAD, RUN, DRAIN}.
  - fp16 constants FP16_ONE=16'h3C00, FP16_ZERO=16'h0000.
- Sub-module `sync_fifo` (WIDTH=64, DEPTH=FIFO_DEPTH; count output, sync active-low reset) for the result buffer. The scheduler FSM and credit logic stay in matmul_sched.

Test Plan:
1. Load identity (0x3C00 on diagonal, 0 elsewhere) while the bench `matmul` is a MM_LATENCY-deep model → vertex {0x3C00,0x4000,0x4200,0x4400} returns identical, with vout_valid exactly 6 cycles after accept.
2. Load diag(2.0)=0x4000, stream 20 back-to-back vertices (1,2,3,4) with vout_ready=1 → 20 results {0x4000,0x4400,0x4600,0x4800} in order, and vin_ready never drops.
3. vout_ready=0 while streaming → exactly 8 vertices accepted, then vin_ready=0. Release → 8 results, no loss; credit assertion holds.
4. With 3 vertices in flight, assert mat_valid with a new matrix → DRAIN. The old 3 results use the old matrix; mat_ready rises only once inflight==0. The next vertex uses the new matrix.
5. rst=0 for one cycle mid-stream (LOAD beat 7, and separately with 4 in flight) → all outputs return to reset values, no stale vout_valid, and the reload and restart succeed.
6. mat_valid and vin_valid asserted together in RUN with vout_ready toggling randomly → vertex accepted, FSM → DRAIN, FIFO never overflows, output order preserved.
